// File: rtl/denorm_shift.sv
// Multi-cycle right-shift denormalizer producing mantissa plus guard/round/sticky.
// Optional DENORM_EARLY_EXIT_EN: finish as soon as no lower shift bits remain.
module denorm_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_mant,
  input  logic [4:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_mant,
  output logic        out_guard,
  output logic        out_round,
  output logic        out_sticky,
  output logic        out_exact
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [25:0] work_q, work_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  sh_q, sh_d;
  logic [2:0]  k_q, k_d;

  logic [4:0]  stage_n;
  logic [4:0]  sh_shr;
  logic [25:0] stage_mask;
  logic        stage_en;
  logic        last_stage;
  logic        idle_to_done;

  // Stage k shifts by 2^k when bit k of the latched amount is set.
  always_comb begin
    stage_n    = 5'd1 << k_q;
    sh_shr     = sh_q >> k_q;
    stage_en   = sh_shr[0];
    stage_mask = (26'd1 << stage_n) - 26'd1;
`ifdef DENORM_EARLY_EXIT_EN
    last_stage   = (sh_q & (stage_n - 5'd1)) == 5'd0;
    idle_to_done = (in_shamt == 5'd0);
`else
    last_stage   = (k_q == 3'd0);
    idle_to_done = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = idle_to_done ? StDone : StShift;
      StShift: if (last_stage) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    work_d   = work_q;
    sticky_d = sticky_q;
    sh_d     = sh_q;
    k_d      = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d   = {in_mant, 2'b00};
          sticky_d = 1'b0;
          sh_d     = in_shamt;
          k_d      = 3'd4;
        end
      end
      StShift: begin
        if (stage_en) begin
          sticky_d = sticky_q | (|(work_q & stage_mask));
          work_d   = work_q >> stage_n;
        end
        if (k_q != 3'd0) k_d = k_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      sticky_q <= 1'b0;
      sh_q     <= '0;
      k_q      <= '0;
    end else begin
      work_q   <= work_d;
      sticky_q <= sticky_d;
      sh_q     <= sh_d;
      k_q      <= k_d;
    end
  end

  assign out_mant   = work_q[25:2];
  assign out_guard  = work_q[1];
  assign out_round  = work_q[0];
  assign out_sticky = sticky_q;
  assign out_exact  = ~(work_q[1] | work_q[0] | sticky_q);

endmodule

// File: tb/tb_denorm_shift.sv
// Directed self-checking bench for denorm_shift; latency expectations follow
// DENORM_EARLY_EXIT_EN when it is defined for the build.
module tb_denorm_shift;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_mant = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_mant;
  logic        out_guard;
  logic        out_round;
  logic        out_sticky;
  logic        out_exact;

  int checks = 0;
  int errors = 0;

  denorm_shift dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_guard  (out_guard),
    .out_round  (out_round),
    .out_sticky (out_sticky),
    .out_exact  (out_exact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] result();
    return {4'd0, out_mant, out_guard, out_round, out_sticky, out_exact};
  endfunction

  function automatic logic [31:0] pack(input logic [23:0] m, input logic g, input logic r,
                                       input logic s);
    return {4'd0, m, g, r, s, ~(g | r | s)};
  endfunction

  function automatic int exp_lat(input logic [4:0] sh);
    int low = 5;
    for (int i = 4; i >= 0; i--) if (sh[i]) low = i;
`ifdef DENORM_EARLY_EXIT_EN
    return (sh == 5'd0) ? 0 : 5 - low;
`else
    return (low > 5) ? 0 : 5;
`endif
  endfunction

  task automatic send(input string tag, input logic [23:0] mant, input logic [4:0] sh);
    @(negedge clk);
    check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_mant  = mant;
    in_shamt = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, exp);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_xfer"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [23:0] mant, input logic [4:0] sh,
                         input logic [31:0] exp);
    send(tag, mant, sh);
    wait_valid(tag, exp_lat(sh));
    check_eq({tag, "_res"}, result(), exp);
    take(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_hs", {30'd0, out_valid, in_ready}, 32'd1);
    check_eq("reset_res", result(), pack(24'h0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    run_vec("pass0", 24'h800000, 5'd0, pack(24'h800000, 1'b0, 1'b0, 1'b0));
    run_vec("sh1", 24'hFFFFFF, 5'd1, pack(24'h7FFFFF, 1'b1, 1'b0, 1'b0));
    run_vec("sh3", 24'h800001, 5'd3, pack(24'h100000, 1'b0, 1'b0, 1'b1));
    run_vec("sh24", 24'hC00000, 5'd24, pack(24'h000000, 1'b1, 1'b1, 1'b0));
    run_vec("sh31", 24'hC00000, 5'd31, pack(24'h000000, 1'b0, 1'b0, 1'b1));

    // Backpressure: result and handshake must hold while new requests knock.
    send("bp", 24'hFFFFFF, 5'd5);
    wait_valid("bp", exp_lat(5'd5));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mant  = 24'h123456;
      in_shamt = 5'd0;
      @(posedge clk);
      #1;
      check_eq("bp_hold_res", result(), pack(24'h07FFFF, 1'b1, 1'b1, 1'b1));
      check_eq("bp_hold_hs", {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take("bp");
    run_vec("after_bp", 24'h123456, 5'd2, pack(24'h048D15, 1'b1, 1'b0, 1'b0));

    // out_ready held high in advance: transfer on the first DONE edge.
    out_ready = 1'b1;
    send("early_rdy", 24'hFFFFFF, 5'd8);
    wait_valid("early_rdy", exp_lat(5'd8));
    check_eq("early_rdy_res", result(), pack(24'h00FFFF, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    check_eq("early_rdy_xfer", {30'd0, out_valid, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Asynchronous reset mid-shift discards the partial result.
    send("rst", 24'hFFFFFF, 5'd31);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_hs", {30'd0, out_valid, in_ready}, 32'd1);
    check_eq("rst_res", result(), pack(24'h0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 24'h800000, 5'd4, pack(24'h080000, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
